instr_fetch: RTL and testbench

//  Instruction fetch unit: the producer feeding the decode stage. Owns the fetch PC and issues word reads to

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants, FSM encoding and small helpers for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [WORD-1:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [WORD-1:0] align_pc(input logic [WORD-1:0] pc);
    return {pc[WORD-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {instruction, pc} with push/pop/flush and occupancy count.
// When empty, the head output holds the last entry that was presented.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_hold;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (r_count != '0) r_hold <= r_mem[r_rd_ptr];
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) begin
          r_mem[r_wr_ptr] <= wdata;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
    end
  end

  assign rdata = (r_count != '0) ? r_mem[r_rd_ptr] : r_hold;
  assign count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads imem over req/ack, buffers into fetch_fifo.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/flushed event counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 64'h0,
  parameter int              DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect,
  input  logic [WORD-1:0]      redirect_pc,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      out_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]          fetched_cnt,
  output logic [31:0]          flushed_cnt,
`endif
  output fetch_state_e         dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e              r_state;
  logic [WORD-1:0]           r_pc_next;
  logic [WORD-1:0]           r_addr;
  logic [CW-1:0]             w_count;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_slot_free_idle;
  logic                      w_slot_free_after_push;
  logic [WORD-1:0]           w_redir_pc;
  logic [INSTR_LEN+WORD-1:0] w_head;

  // Handshakes: decode transfer when out_valid && out_ready; imem read completes when
  // imem_req && imem_ack, with imem_addr held stable for as long as imem_req is high.
  assign w_redir_pc = align_pc(redirect_pc);
  assign out_valid  = (w_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_push     = (r_state == FETCH_WAIT) && imem_ack && !redirect;

  // Occupancy after this edge including the same-cycle pop; a new request needs a free slot.
  assign w_slot_free_idle       = (w_count - CW'(w_pop)) < FULL_CNT;
  assign w_slot_free_after_push = (w_count + CW'(1) - CW'(w_pop)) < FULL_CNT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH_IDLE;
      r_pc_next <= RESET_PC;
      r_addr    <= RESET_PC;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (redirect) begin
            r_pc_next <= w_redir_pc;
          end else if (w_slot_free_idle) begin
            r_state <= FETCH_WAIT;
            r_addr  <= r_pc_next;
          end
        end
        FETCH_WAIT: begin
          if (redirect) begin
            r_pc_next <= w_redir_pc;
            if (imem_ack) r_addr  <= w_redir_pc;
            else          r_state <= FETCH_DRAIN;
          end else if (imem_ack) begin
            r_pc_next <= r_pc_next + PC_STEP;
            if (w_slot_free_after_push) r_addr  <= r_pc_next + PC_STEP;
            else                        r_state <= FETCH_IDLE;
          end
        end
        FETCH_DRAIN: begin
          // r_pc_next doubles as the redirect latch while the abandoned read completes.
          if (redirect) r_pc_next <= w_redir_pc;
          if (imem_ack) begin
            if (redirect) begin
              r_state <= FETCH_IDLE;
            end else begin
              r_state <= FETCH_WAIT;
              r_addr  <= r_pc_next;
            end
          end
        end
        default: r_state <= FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_LEN + WORD)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata ({imem_rdata, r_addr}),
    .rdata (w_head),
    .count (w_count)
  );

  assign imem_req    = (r_state != FETCH_IDLE);
  assign imem_addr   = r_addr;
  assign instruction = w_head[INSTR_LEN+WORD-1:WORD];
  assign out_pc      = w_head[WORD-1:0];
  assign dbg_state   = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetched_cnt;
  logic [31:0] r_flushed_cnt;
  logic [CW:0] w_flush_amt;

  // Flushed work = buffered entries not taken by decode plus any read still in flight.
  assign w_flush_amt = {1'b0, w_count - CW'(w_pop)} + (CW+1)'(r_state == FETCH_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetched_cnt <= '0;
      r_flushed_cnt <= '0;
    end else begin
      if (w_push)   r_fetched_cnt <= sat_add32(r_fetched_cnt, 32'd1);
      if (redirect) r_flushed_cnt <= sat_add32(r_flushed_cnt, 32'(w_flush_amt));
    end
  end

  assign fetched_cnt = r_fetched_cnt;
  assign flushed_cnt = r_flushed_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: imem responder with configurable latency and a
// scoreboard queue of expected PCs consumed as decode accepts instructions.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 redirect;
  logic [WORD-1:0]      redirect_pc;
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_ack;
  logic [INSTR_LEN-1:0] imem_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_LEN-1:0] instruction;
  logic [WORD-1:0]      out_pc;
  fetch_state_e         dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]          fetched_cnt;
  logic [31:0]          flushed_cnt;
`endif

  int          n_vec;
  int          n_err;
  int          mem_lat;
  int          mem_wait;
  bit          lat_rand;
  logic [63:0] exp_q[$];

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .out_pc      (out_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetched_cnt (fetched_cnt),
    .flushed_cnt (flushed_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // instruction memory responder: ack after mem_lat waiting cycles of a held request
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    mem_wait   = 0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (mem_wait >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          mem_wait   = 0;
          if (lat_rand) mem_lat = $urandom_range(0, 2);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          mem_wait++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_wait   = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks; all are entered and left at a negedge
  task automatic do_reset(input int lat);
    reset     = 1'b1;
    redirect  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    mem_lat  = lat;
    lat_rand = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [63:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic push_stream(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  // scoreboard: pop and compare on every decode transfer
  task automatic drain(input bit rand_ready, input int max_cycles);
    int          cyc;
    logic [63:0] e;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < max_cycles) begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("stream_pc", out_pc, e);
        check("stream_instr", 64'(instruction), 64'(mem_word(e)));
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    mem_lat     = 0;
    lat_rand    = 1'b0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_state", 64'(dbg_state), 64'(FETCH_IDLE));

    // zero-wait streaming: req one cycle after release, then one instruction per cycle
    out_ready = 1'b1;
    reset     = 1'b0;
    @(negedge clk);
    check("t1_req_rise", 64'(imem_req), 64'd1);
    check("t1_addr0", imem_addr, 64'h0);
    check("t1_valid_early", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_pc", out_pc, 64'(4 * i));
      check("t1_instr", 64'(instruction), 64'(mem_word(64'(4 * i))));
    end

    // decode stall: FIFO fills to DEPTH, requests stop; release drains in order
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_req_low", 64'(imem_req), 64'd0);
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_state", 64'(dbg_state), 64'(FETCH_IDLE));
    mem_lat   = 4;
    out_ready = 1'b1;
    check("t2_head0", out_pc, 64'd12);
    @(negedge clk);
    check("t2_valid1", 64'(out_valid), 64'd1);
    check("t2_head1", out_pc, 64'd16);
    @(negedge clk);
    check("t2_exact_depth", 64'(out_valid), 64'd0);
    push_stream(64'd20, 2);
    drain(1'b0, 40);

    // slow memory, redirect while waiting: abandoned read is discarded
    do_reset(3);
    @(negedge clk);
    check("t3_req", 64'(imem_req), 64'd1);
    pulse_redirect(64'h100);
    check("t3_state", 64'(dbg_state), 64'(FETCH_DRAIN));
    check("t3_req_held", 64'(imem_req), 64'd1);
    check("t3_addr_held", imem_addr, 64'h0);
    push_stream(64'h100, 2);
    drain(1'b0, 60);

    // redirect coinciding with ack while an entry is buffered
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    check("t4_pre_valid", 64'(out_valid), 64'd1);
    check("t4_pre_pc", out_pc, 64'h0);
    pulse_redirect(64'h200);
    check("t4_flush_valid", 64'(out_valid), 64'd0);
    check("t4_addr", imem_addr, 64'h200);
    check("t4_req", 64'(imem_req), 64'd1);
    check("t4_hold_pc", out_pc, 64'h0);
    check("t4_hold_instr", 64'(instruction), 64'(mem_word(64'h0)));
`ifdef FETCH_PERF_CNT_EN
    check("t4_fetched_cnt", 64'(fetched_cnt), 64'd1);
    check("t4_flushed_cnt", 64'(flushed_cnt), 64'd2);
`endif
    push_stream(64'h200, 3);
    drain(1'b0, 40);

    // PC wrap; low redirect bits are ignored
    out_ready = 1'b0;
    @(negedge clk);
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFFA);
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    drain(1'b0, 40);

    // reset while a request is outstanding
    out_ready = 1'b0;
    mem_lat   = 5;
    @(negedge clk);
    pulse_redirect(64'h300);
    repeat (2) @(negedge clk);
    check("t6_req_pre", 64'(imem_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_req", 64'(imem_req), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_addr", imem_addr, 64'h0);
    check("t6_instr", 64'(instruction), 64'd0);
    check("t6_state", 64'(dbg_state), 64'(FETCH_IDLE));
    mem_lat = 0;
    reset   = 1'b0;
    push_stream(64'h0, 3);
    drain(1'b0, 40);

    // random decode back-pressure and random memory latency
    for (int r = 0; r < 3; r++) begin
      logic [63:0] tgt;
      tgt       = {32'h0, $urandom};
      out_ready = 1'b0;
      lat_rand  = 1'b1;
      @(negedge clk);
      pulse_redirect(tgt);
      push_stream({tgt[63:2], 2'b00}, 20);
      drain(1'b1, 600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
